// File: rtl/csr_pkg.sv
// Shared CSR definitions: address map, operation/source encodings driven by the
// decoder, and the read-modify-write helper used by the CSR unit.
package csr_pkg;

  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  typedef enum logic [1:0] {
    CSR_NA    = 2'b00,
    CSR_PASS  = 2'b01,
    CSR_SET   = 2'b10,
    CSR_CLEAR = 2'b11
  } csr_ctrl_e;

  typedef enum logic {
    CSR_SRC_REG = 1'b0,
    CSR_SRC_IMM = 1'b1
  } csr_src_e;

  function automatic logic [31:0] csr_rmw(input logic [1:0]  ctrl,
                                          input logic [31:0] old,
                                          input logic [31:0] src);
    logic [31:0] res;
    case (ctrl)
      CSR_PASS:  res = src;
      CSR_SET:   res = old | src;
      CSR_CLEAR: res = old & ~src;
      default:   res = old;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independently writable 32-bit halves;
// a write to either half suppresses that edge's increment.
module csr_counter64
  import csr_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] count_o
);

  logic [63:0] count_q;
  logic [63:0] count_d;

  // Next count: explicit write wins, otherwise increment with full 64-bit carry
  always_comb begin
    count_d = count_q;
    if (wr_lo_i) begin
      count_d[31:0] = wdata_i;
    end else if (wr_hi_i) begin
      count_d[63:32] = wdata_i;
    end else if (inc_i) begin
      count_d = count_q + 64'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= 64'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR unit: address decode, combinational read of the pre-write
// value, atomic read-modify-write, illegal-access detection, mscratch and counters.
module csr_unit
  import csr_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        csr_en_i,
  input  logic [11:0] csr_addr_i,
  input  logic [1:0]  csr_control_i,
  input  logic        csr_src_i,
  input  logic [31:0] rs1_data_i,
  input  logic [4:0]  zimm_i,
  input  logic        retire_i,
  output logic [31:0] csr_rdata_o,
  output logic        illegal_o
);

  logic [31:0] mscratch_q;
  logic [31:0] mscratch_d;
  logic [63:0] mcycle;
  logic [63:0] minstret;

  logic [31:0] old_val;
  logic        implemented;
  logic        is_alias;
  logic        wr_intent;
  logic        illegal;
  logic        do_write;
  logic [31:0] src_val;
  logic [31:0] new_val;

  // Address decode and raw read mux
  always_comb begin
    old_val     = 32'd0;
    implemented = 1'b1;
    case (csr_addr_i)
      CSR_MSCRATCH:              old_val = mscratch_q;
      CSR_MCYCLE,   CSR_CYCLE:   old_val = mcycle[31:0];
      CSR_MCYCLEH,  CSR_CYCLEH:  old_val = mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET: old_val = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: old_val = minstret[63:32];
      default: begin
        old_val     = 32'd0;
        implemented = 1'b0;
      end
    endcase
  end

  // Set/clear with a zero operand field is a pure read and may target the aliases
  assign is_alias  = (csr_addr_i[11:8] == 4'hC);
  assign wr_intent = (csr_control_i == CSR_PASS) ||
                     (((csr_control_i == CSR_SET) || (csr_control_i == CSR_CLEAR)) &&
                      (zimm_i != 5'd0));
  assign illegal   = csr_en_i && (!implemented || (wr_intent && is_alias) ||
                                  (csr_control_i == CSR_NA));
  assign do_write  = csr_en_i && !illegal && wr_intent;

  assign src_val = (csr_src_i == CSR_SRC_REG) ? rs1_data_i : {27'd0, zimm_i};
  assign new_val = csr_rmw(csr_control_i, old_val, src_val);

  // Outputs are forced to zero unless a legal access is present
  always_comb begin
    csr_rdata_o = 32'd0;
    illegal_o   = illegal;
    if (csr_en_i && !illegal) begin
      csr_rdata_o = old_val;
    end else begin
      csr_rdata_o = 32'd0;
    end
  end

  // mscratch next value
  always_comb begin
    mscratch_d = mscratch_q;
    if (do_write && (csr_addr_i == CSR_MSCRATCH)) begin
      mscratch_d = new_val;
    end else begin
      mscratch_d = mscratch_q;
    end
  end

  // mscratch register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mscratch_q <= 32'd0;
    end else begin
      mscratch_q <= mscratch_d;
    end
  end

  csr_counter64 u_mcycle (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (1'b1),
    .wr_lo_i (do_write && (csr_addr_i == CSR_MCYCLE)),
    .wr_hi_i (do_write && (csr_addr_i == CSR_MCYCLEH)),
    .wdata_i (new_val),
    .count_o (mcycle)
  );

  csr_counter64 u_minstret (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (retire_i),
    .wr_lo_i (do_write && (csr_addr_i == CSR_MINSTRET)),
    .wr_hi_i (do_write && (csr_addr_i == CSR_MINSTRETH)),
    .wdata_i (new_val),
    .count_o (minstret)
  );

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: directed test-plan sequences plus randomized
// CSR traffic compared against a behavioural model of the CSR file.
module tb_csr_unit;
  import csr_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        csr_en;
  logic [11:0] csr_addr;
  logic [1:0]  csr_control;
  logic        csr_src;
  logic [31:0] rs1_data;
  logic [4:0]  zimm;
  logic        retire;
  logic [31:0] csr_rdata;
  logic        illegal;

  int n_vec = 0;
  int n_err = 0;

  csr_unit dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .csr_en_i      (csr_en),
    .csr_addr_i    (csr_addr),
    .csr_control_i (csr_control),
    .csr_src_i     (csr_src),
    .rs1_data_i    (rs1_data),
    .zimm_i        (zimm),
    .retire_i      (retire),
    .csr_rdata_o   (csr_rdata),
    .illegal_o     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  logic [63:0] m_cycle;
  logic [63:0] m_instret;
  logic [31:0] m_scratch;

  function automatic logic m_impl(input logic [11:0] a);
    return a == 12'h340 || a == 12'hB00 || a == 12'hB80 || a == 12'hB02 || a == 12'hB82 ||
           a == 12'hC00 || a == 12'hC80 || a == 12'hC02 || a == 12'hC82;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    logic [63:0] c;
    if (a == 12'h340) return m_scratch;
    c = (a[1] == 1'b1) ? m_instret : m_cycle;
    return (a[7] == 1'b1) ? c[63:32] : c[31:0];
  endfunction

  function automatic logic m_intent();
    return csr_control == CSR_PASS || (csr_control != CSR_NA && zimm != 5'd0);
  endfunction

  function automatic logic m_illegal();
    return csr_en && (!m_impl(csr_addr) || csr_control == CSR_NA ||
                      (m_intent() && csr_addr[11:8] == 4'hC));
  endfunction

  function automatic logic [31:0] m_rdata();
    return (csr_en && !m_illegal()) ? m_read(csr_addr) : 32'd0;
  endfunction

  function automatic logic [31:0] m_newval();
    logic [31:0] s;
    logic [31:0] o;
    s = csr_src ? {27'd0, zimm} : rs1_data;
    o = m_read(csr_addr);
    if (csr_control == CSR_PASS) return s;
    if (csr_control == CSR_SET) return o | s;
    return o & ~s;
  endfunction

  function automatic logic m_wr(input logic [11:0] a);
    return csr_en && !m_illegal() && m_intent() && csr_addr == a;
  endfunction

  // Model update on each edge; reset clears everything immediately
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cycle   <= 64'd0;
      m_instret <= 64'd0;
      m_scratch <= 32'd0;
    end else begin
      if (m_wr(12'h340)) m_scratch <= m_newval();
      if (m_wr(12'hB00))      m_cycle <= {m_cycle[63:32], m_newval()};
      else if (m_wr(12'hB80)) m_cycle <= {m_newval(), m_cycle[31:0]};
      else                    m_cycle <= m_cycle + 64'd1;
      if (m_wr(12'hB02))      m_instret <= {m_instret[63:32], m_newval()};
      else if (m_wr(12'hB82)) m_instret <= {m_newval(), m_instret[31:0]};
      else if (retire)        m_instret <= m_instret + 64'd1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and compare against the model
  task automatic op(input logic en, input logic [11:0] addr, input logic [1:0] ctrl,
                    input logic src, input logic [31:0] rs1, input logic [4:0] zi,
                    input logic ret);
    @(negedge clk);
    csr_en = en; csr_addr = addr; csr_control = ctrl; csr_src = src;
    rs1_data = rs1; zimm = zi; retire = ret;
    #1;
    check_val("rdata_model", csr_rdata, m_rdata());
    check_val("illegal_model", {31'd0, illegal}, {31'd0, m_illegal()});
  endtask

  task automatic rd(input logic [11:0] addr);
    op(1'b1, addr, CSR_SET, CSR_SRC_IMM, 32'd0, 5'd0, 1'b0);
  endtask

  logic [11:0] addr_tab [11] = '{12'h340, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                                 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h7FF, 12'h341};

  initial begin
    rst_n = 1'b0; csr_en = 1'b0; csr_addr = 12'd0; csr_control = CSR_NA;
    csr_src = CSR_SRC_REG; rs1_data = 32'd0; zimm = 5'd0; retire = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Counting from reset release
    repeat (4) op(1'b0, 12'h000, CSR_NA, CSR_SRC_REG, 32'd0, 5'd0, 1'b0);
    rd(12'hB00);
    check_val("mcycle_after_5", csr_rdata, 32'd5);
    rd(12'hC80);
    check_val("cycleh_zero", csr_rdata, 32'd0);
    check_val("cycleh_legal", {31'd0, illegal}, 32'd0);

    // mscratch read-modify-write chain
    op(1'b1, 12'h340, CSR_PASS, CSR_SRC_REG, 32'hDEADBEEF, 5'd1, 1'b0);
    check_val("rw_old", csr_rdata, 32'd0);
    op(1'b1, 12'h340, CSR_SET, CSR_SRC_IMM, 32'd0, 5'h10, 1'b0);
    check_val("rsi_old", csr_rdata, 32'hDEADBEEF);
    op(1'b1, 12'h340, CSR_CLEAR, CSR_SRC_REG, 32'hFFFF0000, 5'd2, 1'b0);
    check_val("rc_old", csr_rdata, 32'hDEADBEFF);
    rd(12'h340);
    check_val("scratch_final", csr_rdata, 32'h0000BEFF);

    // mcycle low-word carry into high word
    op(1'b1, 12'hB00, CSR_PASS, CSR_SRC_REG, 32'hFFFFFFFF, 5'd3, 1'b0);
    rd(12'hB00);
    check_val("mcycle_written", csr_rdata, 32'hFFFFFFFF);
    rd(12'hB00);
    check_val("mcycle_wrapped_lo", csr_rdata, 32'd0);
    rd(12'hB80);
    check_val("mcycle_carry_hi", csr_rdata, 32'd1);

    // minstret write beats simultaneous retire
    op(1'b1, 12'hB02, CSR_PASS, CSR_SRC_REG, 32'h100, 5'd4, 1'b1);
    op(1'b1, 12'hB02, CSR_SET, CSR_SRC_IMM, 32'd0, 5'd0, 1'b1);
    check_val("minstret_written", csr_rdata, 32'h100);
    rd(12'hB02);
    check_val("minstret_retired", csr_rdata, 32'h101);

    // Alias and illegal accesses
    rd(12'hC00);
    check_val("alias_read_legal", {31'd0, illegal}, 32'd0);
    op(1'b1, 12'hC00, CSR_PASS, CSR_SRC_REG, 32'h12345678, 5'd5, 1'b0);
    check_val("alias_write_illegal", {31'd0, illegal}, 32'd1);
    check_val("alias_write_rdata", csr_rdata, 32'd0);
    op(1'b1, 12'h7FF, CSR_SET, CSR_SRC_IMM, 32'd0, 5'd0, 1'b0);
    check_val("unimpl_illegal", {31'd0, illegal}, 32'd1);
    op(1'b1, 12'h340, CSR_NA, CSR_SRC_REG, 32'd0, 5'd0, 1'b0);
    check_val("na_illegal", {31'd0, illegal}, 32'd1);
    rd(12'h340);
    check_val("scratch_kept", csr_rdata, 32'h0000BEFF);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [11:0] a;
      a = ($urandom_range(0, 9) == 0) ? 12'($urandom) : addr_tab[$urandom_range(0, 10)];
      op(1'($urandom_range(0, 3) != 0), a, 2'($urandom), 1'($urandom),
         ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom,
         ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), 1'($urandom));
    end

    // Asynchronous reset in mid-cycle
    op(1'b1, 12'h340, CSR_PASS, CSR_SRC_REG, 32'h1234, 5'd6, 1'b0);
    rd(12'h340);
    check_val("scratch_pre_reset", csr_rdata, 32'h1234);
    #2 rst_n = 1'b0;
    #1 check_val("reset_scratch", csr_rdata, 32'd0);
    csr_addr = 12'hB00;
    #1 check_val("reset_mcycle", csr_rdata, 32'd0);
    check_val("reset_model", csr_rdata, m_rdata());
    @(negedge clk);
    rst_n = 1'b1;
    rd(12'hB00);
    check_val("restart_count", csr_rdata, 32'd1);
    rd(12'hB02);
    check_val("restart_minstret", csr_rdata, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
